mem_responder: RTL and testbench

- Memory-side responder for the CPU datapath's load/store/fetch port. Serves one request at a time over a valid/ready request channel and a valid-pulse response channel.
- Backs requests with internal word-addressed RAM.
- Decodes a small memory-mapped I/O window: LED register, synchronized switch input, free-running timer.
- Sits between the CPU datapath's memory address, store-data and load-data signals and the board I/O.

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Purpose: memory-side responder for the CPU load/store/fetch port; RAM plus LED/switch/timer I/O window.
// Latency: write ack pulses 1 cycle after accept, read data pulses 2 cycles after accept.
// Backpressure: req_ready only in IDLE, one request outstanding; resp_valid is a pulse with no ready.
module mem_responder #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_BITS = 10,
  parameter logic [WIDTH-1:0] IO_BASE   = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] leds,
  output logic             addr_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_BITS;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             rd_is_ram_q, rd_is_ram_d;
  logic             addr_err_q, addr_err_d;
  logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0] ram_rdata_q;
  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  logic             accept;
  logic             ram_sel, led_sel, sw_sel, timer_sel, unmapped;
  logic [WIDTH-1:0] io_rdata;

  // Ready is gated by the reset input so nothing is accepted while reset is held.
  assign req_ready  = (state_q == IDLE) && reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign leds       = leds_q;
  assign addr_error = addr_err_q;

  // Address decode of the current request.
  always_comb begin
    ram_sel   = (req_addr[WIDTH-1:ADDR_BITS] == '0);
    led_sel   = (req_addr == IO_BASE);
    sw_sel    = (req_addr == (IO_BASE + WIDTH'(1)));
    timer_sel = (req_addr == (IO_BASE + WIDTH'(2)));
    unmapped  = !(ram_sel || led_sel || sw_sel || timer_sel);
  end

  // I/O read mux; unmapped and RAM addresses read as zero here (RAM goes via its own port).
  always_comb begin
    io_rdata = '0;
    if (led_sel) begin
      io_rdata = leds_q;
    end else if (sw_sel) begin
      io_rdata = sw_sync_q;
    end else if (timer_sel) begin
      io_rdata = timer_q;
    end
  end

  // FSM next state: one outstanding request, writes skip the RD cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_write ? RESP : RD;
        end
      end
      RD:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: I/O register updates, read capture and response data.
  always_comb begin
    leds_d       = leds_q;
    timer_d      = timer_q + WIDTH'(1);
    hold_d       = hold_q;
    rd_is_ram_d  = rd_is_ram_q;
    addr_err_d   = addr_err_q;
    resp_rdata_d = resp_rdata_q;

    if (accept) begin
      addr_err_d = addr_err_q | unmapped;
      if (req_write) begin
        // A timer write overrides this edge's increment.
        if (led_sel) begin
          leds_d = req_wdata;
        end
        if (timer_sel) begin
          timer_d = req_wdata;
        end
        resp_rdata_d = '0;
      end else begin
        hold_d      = io_rdata;
        rd_is_ram_d = ram_sel;
      end
    end

    if (state_q == RD) begin
      resp_rdata_d = rd_is_ram_q ? ram_rdata_q : hold_q;
    end
  end

  // State and I/O registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      leds_q       <= '0;
      timer_q      <= '0;
      hold_q       <= '0;
      rd_is_ram_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
    end else begin
      state_q      <= state_d;
      leds_q       <= leds_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      rd_is_ram_q  <= rd_is_ram_d;
      addr_err_q   <= addr_err_d;
      resp_rdata_q <= resp_rdata_d;
      sw_meta_q    <= switches;
      sw_sync_q    <= sw_meta_q;
    end
  end

  // Word RAM: write and synchronous read both happen at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && ram_sel) begin
      mem_q[req_addr[ADDR_BITS-1:0]] <= req_wdata;
    end
    if (accept && !req_write) begin
      ram_rdata_q <= mem_q[req_addr[ADDR_BITS-1:0]];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, RAM, streaming backpressure, I/O window,
// unmapped accesses and reset during a read. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        addr_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .WIDTH    (16),
    .ADDR_BITS(10),
    .IO_BASE  (16'hFF00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .switches  (switches),
    .leds      (leds),
    .addr_error(addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from a falling edge; returns at the falling edge where resp_valid is seen.
  // lat counts falling edges after the accept edge; ae1 is addr_error one half-cycle after accept.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic [15:0] lat, output logic ae1);
    int n;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 16'(req_ready), 16'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    ae1 = addr_error;
    lat = 16'd1;
    while (!resp_valid && lat < 16'd8) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
  endtask

  logic [15:0] rd, lat;
  logic        ae1;
  logic [15:0] exp_q [$];
  int          cyc, idx, acks;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0005;
    req_wdata = 16'h0000;
    switches  = 16'h0000;

    // Reset held for 3 cycles with a request pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_resp_valid", 16'(resp_valid), 16'd0);
      check("rst_leds", leds, 16'h0000);
      check("rst_addr_error", 16'(addr_error), 16'd0);
      check("rst_req_ready", 16'(req_ready), 16'd0);
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    check("ready_after_release", 16'(req_ready), 16'd1);
    @(negedge clk);
    check("resp_rdata_after_reset", resp_rdata, 16'h0000);

    // RAM write / read round trips.
    do_req(1'b1, 16'h0005, 16'hBEEF, rd, lat, ae1);
    check("ram_wr_lat", lat, 16'd1);
    check("ram_wr_ack_rdata", rd, 16'h0000);
    do_req(1'b0, 16'h0005, 16'h0000, rd, lat, ae1);
    check("ram_rd_lat", lat, 16'd2);
    check("ram_rd_data", rd, 16'hBEEF);
    do_req(1'b1, 16'h03FF, 16'h1234, rd, lat, ae1);
    do_req(1'b0, 16'h03FF, 16'h0000, rd, lat, ae1);
    check("ram_top_addr", rd, 16'h1234);
    do_req(1'b1, 16'h0007, 16'h7007, rd, lat, ae1);
    do_req(1'b1, 16'h0307, 16'h3307, rd, lat, ae1);

    // LED register.
    do_req(1'b1, 16'hFF00, 16'h00A5, rd, lat, ae1);
    check("led_wr_lat", lat, 16'd1);
    check("leds_after_write", leds, 16'h00A5);
    do_req(1'b0, 16'hFF00, 16'h0000, rd, lat, ae1);
    check("led_readback", rd, 16'h00A5);

    // Switches through the synchronizer; writes are ignored.
    switches = 16'h0F0F;
    repeat (3) @(negedge clk);
    do_req(1'b0, 16'hFF01, 16'h0000, rd, lat, ae1);
    check("switch_read", rd, 16'h0F0F);
    do_req(1'b1, 16'hFF01, 16'h5555, rd, lat, ae1);
    do_req(1'b0, 16'hFF01, 16'h0000, rd, lat, ae1);
    check("switch_read_only", rd, 16'h0F0F);

    // Timer: written FFFE at edge N, read accepted at edge N+5 sees FFFE+4 = 0002.
    do_req(1'b1, 16'hFF02, 16'hFFFE, rd, lat, ae1);
    repeat (4) @(negedge clk);
    do_req(1'b0, 16'hFF02, 16'h0000, rd, lat, ae1);
    check("timer_wrap", rd, 16'h0002);

    // Ten back-to-back writes with req_valid held high: 2 cycles each.
    @(negedge clk);
    req_valid = 1'b1;
    cyc = 0; idx = 0; acks = 0;
    while (acks < 10 && cyc < 60) begin
      if (resp_valid) acks++;
      if (req_ready) begin
        if (idx < 10) begin
          req_write = 1'b1;
          req_addr  = 16'h0010 + 16'(idx);
          req_wdata = 16'h0100 + 16'(idx);
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
      cyc++;
      if (acks < 10) @(negedge clk);
    end
    req_valid = 1'b0;
    check("stream_wr_acks", 16'(acks), 16'd10);
    check("stream_wr_cycles", 16'(cyc), 16'd20);
    @(negedge clk);
    do_req(1'b0, 16'h0010, 16'h0000, rd, lat, ae1);
    check("stream_wr_first", rd, 16'h0100);
    do_req(1'b0, 16'h0015, 16'h0000, rd, lat, ae1);
    check("stream_wr_mid", rd, 16'h0105);
    do_req(1'b0, 16'h0019, 16'h0000, rd, lat, ae1);
    check("stream_wr_last", rd, 16'h0109);

    // Alternating write/read stream with req_valid held high: 5*2 + 5*3 cycles.
    @(negedge clk);
    req_valid = 1'b1;
    cyc = 0; idx = 0; acks = 0;
    exp_q.delete();
    while (acks < 10 && cyc < 80) begin
      if (resp_valid) begin
        acks++;
        if (exp_q.size() > 0) check("alt_rdata", resp_rdata, exp_q.pop_front());
      end
      if (req_ready) begin
        if (idx < 10) begin
          req_write = (idx % 2 == 0);
          req_addr  = 16'h0040 + 16'(idx / 2);
          req_wdata = 16'hC000 + 16'(idx);
          if (idx % 2 == 0) exp_q.push_back(16'h0000);
          else              exp_q.push_back(16'hC000 + 16'(idx - 1));
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
      cyc++;
      if (acks < 10) @(negedge clk);
    end
    req_valid = 1'b0;
    check("stream_alt_acks", 16'(acks), 16'd10);
    check("stream_alt_cycles", 16'(cyc), 16'd25);

    // Unmapped accesses.
    check("addr_error_clear_before", 16'(addr_error), 16'd0);
    do_req(1'b0, 16'h0400, 16'h0000, rd, lat, ae1);
    check("unmapped_rd_data", rd, 16'h0000);
    check("unmapped_rd_lat", lat, 16'd2);
    check("unmapped_err_at_accept", 16'(ae1), 16'd1);
    do_req(1'b0, 16'h0005, 16'h0000, rd, lat, ae1);
    check("ram_after_unmapped", rd, 16'hBEEF);
    check("addr_error_sticky", 16'(addr_error), 16'd1);
    do_req(1'b1, 16'hFF07, 16'h5555, rd, lat, ae1);
    check("unmapped_wr_leds", leds, 16'h00A5);
    do_req(1'b0, 16'h0007, 16'h0000, rd, lat, ae1);
    check("unmapped_wr_ram_low", rd, 16'h7007);
    do_req(1'b0, 16'h0307, 16'h0000, rd, lat, ae1);
    check("unmapped_wr_ram_alias", rd, 16'h3307);
    check("addr_error_still_set", 16'(addr_error), 16'd1);

    // Reset asserted while a read is in RD: no response, committed RAM write survives.
    do_req(1'b1, 16'h0033, 16'h7777, rd, lat, ae1);
    req_write = 1'b0;
    req_addr  = 16'h0033;
    req_valid = 1'b1;
    @(negedge clk);
    check("midrd_ready", 16'(req_ready), 16'd1);
    @(posedge clk);
    @(negedge clk);
    check("midrd_in_rd", 16'(resp_valid), 16'd0);
    reset     = 1'b0;
    req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrd_no_resp", 16'(resp_valid), 16'd0);
    end
    check("midrd_addr_error_cleared", 16'(addr_error), 16'd0);
    check("midrd_leds_cleared", leds, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, 16'h0033, 16'h0000, rd, lat, ae1);
    check("midrd_ram_kept", rd, 16'h7777);
    check("midrd_rd_lat", lat, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
